imem_refill_arbiter: RTL and testbench
======================================

Name: imem_refill_arbiter

Overview:
Sequences the single, slow (8-cycle) instruction-memory read port and shares it between two requesters: I-cache demand refills on a miss, and a next-line prefetcher. It owns the memory read handshake, aligns addresses to 32-byte lines and strobes the I-cache line fill. A demand for a line already being prefetched is merged into that read, not re-issued. Sits between the control path's miss logic/prefetcher and Inst_Mem/I_cache.

Parameters:
ADDR_W, 32, byte-address width
LINE_BYTES, 32, bytes per cache line (8 words); low log2 bits cleared for line alignment
PF_AGE_MAX, 4, cycles a waiting prefetch may lose to demand before it is forced ahead
TIMEOUT_CYC, 32, WAIT cycles without mem_valid before abort

Ports:
clk  in  1  clock, all state on rising edge
start  in  1  reset, asynchronous, active-high
dem_req  in  1  demand refill request, held until dem_gnt
dem_addr  in  ADDR_W  demand miss byte address
dem_gnt  out  1  1-cycle pulse: demand accepted (issued or merged)
dem_done  out  1  1-cycle pulse: demand line written into cache
pf_req  in  1  prefetch request, held until pf_gnt or withdrawn
pf_addr  in  ADDR_W  prefetch byte address
pf_gnt  out  1  1-cycle pulse: prefetch accepted
pf_done  out  1  1-cycle pulse: prefetch line written
mem_read  out  1  level read request to Inst_Mem, high throughout WAIT
mem_addr  out  ADDR_W  line-aligned address, stable while mem_read high
mem_valid  in  1  Inst_Mem line data valid (1 cycle)
cache_fill  out  1  1-cycle strobe to I_cache update input
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set on abort, cleared only by start

Behaviour:
- Reset (start=1, any cycle): FSM to IDLE; all outputs 0, mem_addr=0. Age counter, timer and merge flag cleared. Any in-flight read is abandoned.
- States:
  - IDLE: requests sampled; grant registered.
  - WAIT: mem_read=1; timer counts.
  - FILL: one cycle; cache_fill=1 plus the owner's done pulse(s); returns to IDLE.
- Arbitration in IDLE:
  - Demand wins if pf_age<PF_AGE_MAX.
  - If pf_req and pf_age==PF_AGE_MAX, prefetch wins.
  - Winner's gnt pulses the next cycle; mem_read rises in that same cycle; FSM enters WAIT.
  - mem_addr = req_addr with low log2(LINE_BYTES) bits zeroed, latched at grant.
- Age counter:
  - Increments when pf_req=1 and the demand is granted instead; saturates at PF_AGE_MAX.
  - Clears on pf_gnt or when pf_req=0 in IDLE.
- Withdrawal: a requester dropping req before gnt is legal; no grant is issued.
- WAIT:
  - mem_valid=1 moves to FILL next cycle; mem_read drops in FILL.
  - Timer reaching TIMEOUT_CYC-1 with no mem_valid: drop mem_read, set timeout_err, pulse the owner's done with no cache_fill, return to IDLE.
  - mem_valid in the same cycle as timeout: valid wins.
- Merge (owner=prefetch, in WAIT):
  - If dem_req and aligned dem_addr == mem_addr, pulse dem_gnt the next cycle and set the merge flag.
  - In FILL, dem_done and pf_done pulse together with cache_fill.
  - At most one merge per read.
- Demand to a different line while busy stays pending; it is arbitrated on return to IDLE (earliest grant = cycle after FILL).
- mem_valid seen in IDLE or FILL is ignored.
- Latency: req at cycle t (IDLE) → gnt t+1 → mem_valid t+1+8 → cache_fill/done t+10.

Decomposition:
- Shared package riscv_mem_pkg:
  - LINE_BYTES and LINE_OFF_W constants.
  - State enum {IDLE, WAIT, FILL}.
  - Owner encoding {OWN_DEM, OWN_PF}.
  - Line-align function.
- One sub-module, refill_timer: a saturating counter with clear/enable and a terminal-count output. It is instantiated twice: once as the WAIT timeout timer and once as the prefetch age counter.

Test Plan:
- Demand only: dem_req with dem_addr=0x0000_0124 at t=0 → dem_gnt t=1, mem_addr=0x0000_0120, mem_valid at t=9 → cache_fill+dem_done at t=10, busy low at t=11.
- Simultaneous dem_req (0x40) and pf_req (0x80) → demand granted first; prefetch granted in the first IDLE after FILL; pf_age=1 recorded.
- Starvation: pf_req held while 4 back-to-back demands win → 5th arbitration grants prefetch even with dem_req=1.
- Merge: prefetch 0x200 in WAIT, dem_req 0x21C → dem_gnt next cycle, no second mem_read, dem_done and pf_done in the same cycle as the single cache_fill.
- Timeout: mem_valid never arrives → mem_read drops after 32 WAIT cycles, timeout_err=1 and stays 1, dem_done pulses with no cache_fill.
- Reset mid-WAIT: start=1 at cycle 5 of WAIT → all outputs 0 immediately; a late mem_valid after release causes no fill.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared constants, state/owner encodings and line alignment for the I-mem refill path.
package riscv_mem_pkg;

   localparam int unsigned LINE_BYTES = 32;
   localparam int unsigned LINE_OFF_W = $clog2(LINE_BYTES);
   localparam int unsigned ALIGN_W    = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      FILL = 2'd2
   } state_t;

   typedef enum logic {
      OWN_DEM = 1'b0,
      OWN_PF  = 1'b1
   } owner_t;

   // Clear the byte-offset bits so the address points at the start of its line.
   function automatic logic [ALIGN_W-1:0] line_align(input logic [ALIGN_W-1:0] addr);
      return addr & ~ALIGN_W'(LINE_BYTES - 1);
   endfunction

endpackage

// File: rtl/refill_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
module refill_timer #(
   parameter int unsigned MAX = 4
) (
   input  logic clk,
   input  logic start,
   input  logic clr,
   input  logic en,
   output logic tc_c
);

   localparam int unsigned CNT_W = (MAX < 2) ? 1 : $clog2(MAX + 1);

   logic [CNT_W-1:0] count;

   // Count up while enabled, hold at MAX; clear has priority.
   always_ff @(posedge clk or posedge start) begin
      if (start) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != CNT_W'(MAX))) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc_c = (count == CNT_W'(MAX));

endmodule

// File: rtl/imem_refill_arbiter.sv
// Shares the slow I-mem read port between demand refills and the next-line prefetcher.
module imem_refill_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned PF_AGE_MAX  = 4,
   parameter int unsigned TIMEOUT_CYC = 32
) (
   input  logic              clk,
   input  logic              start,
   input  logic              dem_req,
   input  logic [ADDR_W-1:0] dem_addr,
   output logic              dem_gnt,
   output logic              dem_done,
   input  logic              pf_req,
   input  logic [ADDR_W-1:0] pf_addr,
   output logic              pf_gnt,
   output logic              pf_done,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   output logic              cache_fill,
   output logic              busy,
   output logic              timeout_err
);

   state_t            state, state_nxt;
   owner_t            owner, owner_nxt;
   logic              merged, merged_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              dem_gnt_nxt, dem_done_nxt, pf_gnt_nxt, pf_done_nxt;
   logic              cache_fill_nxt, mem_read_nxt, busy_nxt;
   logic              abort;
   logic              age_en, age_clr, age_tc;
   logic              tmr_tc;
   logic              pf_wins;
   logic [ADDR_W-1:0] dem_line, pf_line;

   assign dem_line = ADDR_W'(line_align(ALIGN_W'(dem_addr)));
   assign pf_line  = ADDR_W'(line_align(ALIGN_W'(pf_addr)));

   // A starved prefetch overrides a concurrent demand once its age saturates.
   assign pf_wins = pf_req && (!dem_req || age_tc);

   // WAIT-state watchdog; runs only while a read is outstanding.
   refill_timer #(.MAX(TIMEOUT_CYC - 1)) u_wait_tmr (
      .clk   (clk),
      .start (start),
      .clr   (state != WAIT),
      .en    (state == WAIT),
      .tc_c  (tmr_tc)
   );

   // Counts demand wins over a waiting prefetch.
   refill_timer #(.MAX(PF_AGE_MAX)) u_pf_age (
      .clk   (clk),
      .start (start),
      .clr   (age_clr),
      .en    (age_en),
      .tc_c  (age_tc)
   );

   // Next-state, arbitration, merge and next-output logic.
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      merged_nxt     = merged;
      addr_nxt       = mem_addr;
      dem_gnt_nxt    = 1'b0;
      dem_done_nxt   = 1'b0;
      pf_gnt_nxt     = 1'b0;
      pf_done_nxt    = 1'b0;
      cache_fill_nxt = 1'b0;
      abort          = 1'b0;
      age_en         = 1'b0;
      age_clr        = 1'b0;

      case (state)
         IDLE: begin
            if (pf_wins) begin
               state_nxt  = WAIT;
               owner_nxt  = OWN_PF;
               merged_nxt = 1'b0;
               addr_nxt   = pf_line;
               pf_gnt_nxt = 1'b1;
               age_clr    = 1'b1;
            end else if (dem_req) begin
               state_nxt   = WAIT;
               owner_nxt   = OWN_DEM;
               merged_nxt  = 1'b0;
               addr_nxt    = dem_line;
               dem_gnt_nxt = 1'b1;
               age_en      = pf_req;
               age_clr     = !pf_req;
            end else begin
               age_clr = 1'b1;
            end
         end

         WAIT: begin
            if (mem_valid) begin
               state_nxt      = FILL;
               cache_fill_nxt = 1'b1;
               dem_done_nxt   = (owner == OWN_DEM) || merged;
               pf_done_nxt    = (owner == OWN_PF);
            end else if (tmr_tc) begin
               state_nxt    = IDLE;
               abort        = 1'b1;
               dem_done_nxt = (owner == OWN_DEM) || merged;
               pf_done_nxt  = (owner == OWN_PF);
            end else if ((owner == OWN_PF) && !merged && dem_req && (dem_line == mem_addr)) begin
               dem_gnt_nxt = 1'b1;
               merged_nxt  = 1'b1;
            end
         end

         FILL: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      mem_read_nxt = (state_nxt == WAIT);
      busy_nxt     = (state_nxt != IDLE);
   end

   // State register and registered outputs.
   always_ff @(posedge clk or posedge start) begin
      if (start) begin
         state       <= IDLE;
         owner       <= OWN_DEM;
         merged      <= 1'b0;
         mem_addr    <= '0;
         dem_gnt     <= 1'b0;
         dem_done    <= 1'b0;
         pf_gnt      <= 1'b0;
         pf_done     <= 1'b0;
         cache_fill  <= 1'b0;
         mem_read    <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         merged      <= merged_nxt;
         mem_addr    <= addr_nxt;
         dem_gnt     <= dem_gnt_nxt;
         dem_done    <= dem_done_nxt;
         pf_gnt      <= pf_gnt_nxt;
         pf_done     <= pf_done_nxt;
         cache_fill  <= cache_fill_nxt;
         mem_read    <= mem_read_nxt;
         busy        <= busy_nxt;
         timeout_err <= timeout_err | abort;
      end
   end

endmodule

// File: tb/tb_imem_refill_arbiter.sv
// Scoreboard bench for imem_refill_arbiter: directed stimulus, queued expectations, event monitor.
module tb_imem_refill_arbiter;

   localparam int unsigned ADDR_W  = 32;
   localparam int          MEM_LAT = 8;

   typedef struct {
      logic [38:0] v;
      int          cyc;
   } exp_t;

   logic              clk;
   logic              start;
   logic              dem_req;
   logic [ADDR_W-1:0] dem_addr;
   logic              dem_gnt;
   logic              dem_done;
   logic              pf_req;
   logic [ADDR_W-1:0] pf_addr;
   logic              pf_gnt;
   logic              pf_done;
   logic              mem_read;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_valid;
   logic              cache_fill;
   logic              busy;
   logic              timeout_err;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   k     = 0;
   logic mem_on;
   logic late_pulse;
   exp_t sb[$];

   imem_refill_arbiter #(.ADDR_W(ADDR_W), .PF_AGE_MAX(4), .TIMEOUT_CYC(32)) dut (
      .clk         (clk),
      .start       (start),
      .dem_req     (dem_req),
      .dem_addr    (dem_addr),
      .dem_gnt     (dem_gnt),
      .dem_done    (dem_done),
      .pf_req      (pf_req),
      .pf_addr     (pf_addr),
      .pf_gnt      (pf_gnt),
      .pf_done     (pf_done),
      .mem_read    (mem_read),
      .mem_addr    (mem_addr),
      .mem_valid   (mem_valid),
      .cache_fill  (cache_fill),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_ev(input logic gd, input logic gp, input logic cf, input logic dd,
                            input logic pd, input logic mr, input logic te,
                            input logic [31:0] a, input int c);
      exp_t e;
      e.v   = {gd, gp, cf, dd, pd, mr, te, a};
      e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, 64'({dem_gnt, dem_done, pf_gnt, pf_done, mem_read, cache_fill, busy,
                     timeout_err, mem_addr}), 64'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      start   = 1'b1;
      dem_req = 1'b0;
      pf_req  = 1'b0;
      #1;
      chk_all_zero("reset_outputs");
      @(negedge clk);
      start = 1'b0;
   endtask

   // Memory model: returns line data MEM_LAT cycles after the read is issued.
   initial begin
      mem_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_read) k++;
         else k = 0;
         mem_valid = (mem_on && (k == MEM_LAT + 1)) || late_pulse;
      end
   end

   // Monitor: every output pulse is matched against the next queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (dem_gnt || pf_gnt || cache_fill || dem_done || pf_done) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_event: actual=%b required=none (cycle %0d)",
                        {dem_gnt, pf_gnt, cache_fill, dem_done, pf_done}, cyc);
            end else begin
               e = sb.pop_front();
               chk("event_cycle", 64'(cyc), 64'(e.cyc));
               chk("event_outputs", 64'({dem_gnt, pf_gnt, cache_fill, dem_done, pf_done,
                                         mem_read, timeout_err, mem_addr}), 64'(e.v));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      start      = 1'b1;
      dem_req    = 1'b0;
      dem_addr   = '0;
      pf_req     = 1'b0;
      pf_addr    = '0;
      mem_on     = 1'b1;
      late_pulse = 1'b0;
      do_reset();

      // Demand only: 0x124 -> line 0x120, fill ten cycles after request.
      @(negedge clk);
      t0 = cyc;
      dem_addr = 32'h0000_0124;
      dem_req  = 1'b1;
      expect_ev(1, 0, 0, 0, 0, 1, 0, 32'h120, t0 + 1);
      expect_ev(0, 0, 1, 1, 0, 0, 0, 32'h120, t0 + 10);
      wait_cyc(t0 + 1);
      dem_req = 1'b0;
      chk("t1_busy_wait", 64'(busy), 64'(1));
      wait_cyc(t0 + 10);
      chk("t1_busy_fill", 64'(busy), 64'(1));
      wait_cyc(t0 + 11);
      chk("t1_busy_idle", 64'(busy), 64'(0));

      // Simultaneous requests: demand first, prefetch after the demand's fill.
      t0 = cyc;
      dem_addr = 32'h40;
      dem_req  = 1'b1;
      pf_addr  = 32'h80;
      pf_req   = 1'b1;
      expect_ev(1, 0, 0, 0, 0, 1, 0, 32'h40, t0 + 1);
      expect_ev(0, 0, 1, 1, 0, 0, 0, 32'h40, t0 + 10);
      expect_ev(0, 1, 0, 0, 0, 1, 0, 32'h80, t0 + 12);
      expect_ev(0, 0, 1, 0, 1, 0, 0, 32'h80, t0 + 21);
      wait_cyc(t0 + 1);
      dem_req = 1'b0;
      wait_cyc(t0 + 12);
      pf_req = 1'b0;
      wait_cyc(t0 + 22);

      // Starvation: four demand wins, then the aged prefetch is forced ahead.
      t0 = cyc;
      pf_addr  = 32'h300;
      pf_req   = 1'b1;
      dem_addr = 32'h1008;
      dem_req  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_ev(1, 0, 0, 0, 0, 1, 0, 32'h1000 + 32'(i * 32'h40), t0 + 1 + 11 * i);
         expect_ev(0, 0, 1, 1, 0, 0, 0, 32'h1000 + 32'(i * 32'h40), t0 + 10 + 11 * i);
      end
      expect_ev(0, 1, 0, 0, 0, 1, 0, 32'h300, t0 + 45);
      expect_ev(0, 0, 1, 0, 1, 0, 0, 32'h300, t0 + 54);
      expect_ev(1, 0, 0, 0, 0, 1, 0, 32'h1100, t0 + 56);
      expect_ev(0, 0, 1, 1, 0, 0, 0, 32'h1100, t0 + 65);
      for (int i = 0; i < 4; i++) begin
         wait_cyc(t0 + 1 + 11 * i);
         dem_addr = 32'h1008 + 32'((i + 1) * 32'h40);
      end
      wait_cyc(t0 + 45);
      pf_req = 1'b0;
      wait_cyc(t0 + 56);
      dem_req = 1'b0;
      wait_cyc(t0 + 66);

      // Merge: demand to the line being prefetched rides the same read.
      t0 = cyc;
      pf_addr = 32'h200;
      pf_req  = 1'b1;
      expect_ev(0, 1, 0, 0, 0, 1, 0, 32'h200, t0 + 1);
      wait_cyc(t0 + 1);
      pf_req = 1'b0;
      wait_cyc(t0 + 3);
      dem_addr = 32'h21C;
      dem_req  = 1'b1;
      expect_ev(1, 0, 0, 0, 0, 1, 0, 32'h200, t0 + 4);
      expect_ev(0, 0, 1, 1, 1, 0, 0, 32'h200, t0 + 10);
      wait_cyc(t0 + 4);
      dem_req = 1'b0;
      wait_cyc(t0 + 11);
      chk("t4_no_reread", 64'({mem_read, busy}), 64'(0));
      wait_cyc(t0 + 12);
      chk("t4_no_reread2", 64'({mem_read, busy}), 64'(0));

      // Timeout: no mem_valid, abort after 32 WAIT cycles, sticky error.
      t0 = cyc;
      mem_on   = 1'b0;
      dem_addr = 32'h3004;
      dem_req  = 1'b1;
      expect_ev(1, 0, 0, 0, 0, 1, 0, 32'h3000, t0 + 1);
      expect_ev(0, 0, 0, 1, 0, 0, 1, 32'h3000, t0 + 33);
      wait_cyc(t0 + 1);
      dem_req = 1'b0;
      wait_cyc(t0 + 32);
      chk("t5_read_last_wait", 64'({mem_read, timeout_err}), 64'(2'b10));
      wait_cyc(t0 + 40);
      chk("t5_err_sticky", 64'({timeout_err, busy, mem_read}), 64'(3'b100));
      mem_on   = 1'b1;
      dem_addr = 32'h3100;
      dem_req  = 1'b1;
      expect_ev(1, 0, 0, 0, 0, 1, 1, 32'h3100, t0 + 41);
      expect_ev(0, 0, 1, 1, 0, 0, 1, 32'h3100, t0 + 50);
      wait_cyc(t0 + 41);
      dem_req = 1'b0;
      wait_cyc(t0 + 51);
      chk("t5_err_after_fill", 64'(timeout_err), 64'(1));

      // Reset mid-WAIT, then a stray mem_valid in IDLE must not fill.
      do_reset();
      chk("t6_err_cleared", 64'(timeout_err), 64'(0));
      @(negedge clk);
      t0 = cyc;
      mem_on   = 1'b0;
      dem_addr = 32'h4000;
      dem_req  = 1'b1;
      expect_ev(1, 0, 0, 0, 0, 1, 0, 32'h4000, t0 + 1);
      wait_cyc(t0 + 1);
      dem_req = 1'b0;
      wait_cyc(t0 + 5);
      start = 1'b1;
      #1;
      chk_all_zero("t6_reset_mid_wait");
      wait_cyc(t0 + 7);
      start      = 1'b0;
      late_pulse = 1'b1;
      wait_cyc(t0 + 8);
      late_pulse = 1'b0;
      wait_cyc(t0 + 9);
      chk("t6_no_fill", 64'({cache_fill, busy, dem_done}), 64'(0));
      wait_cyc(t0 + 10);
      chk("t6_no_fill2", 64'({cache_fill, busy, dem_done, mem_read}), 64'(0));
      mem_on = 1'b1;

      wait_cyc(t0 + 12);
      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
